// File: rtl/ssd_display_controller_pkg.sv
// Shared types and constants for the seven-segment display controller:
// FSM state encoding, operand widths and the double-dabble digit correction.
package ssd_pkg;

    localparam int NUM_W      = 13;
    localparam int NUM_DIGITS = 4;
    localparam int BCD_W      = 16;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    // Any BCD digit of 5 or more gets 3 added, so it carries correctly on the next shift.
    function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        return res;
    endfunction

endpackage

// File: rtl/ssd_display_controller_if.sv
// Bundle of source values, control and BCD result between the display
// controller and whatever feeds or consumes it.
interface ssd_display_controller_if;
    import ssd_pkg::*;

    logic [NUM_W-1:0] src0;
    logic [NUM_W-1:0] src1;
    logic [NUM_W-1:0] src2;
    logic [NUM_W-1:0] src3;
    logic             lock;
    logic [1:0]       sel;
    logic [BCD_W-1:0] digits;
    logic             digits_valid;
    logic             busy;

    modport master (
        output src0, src1, src2, src3, lock,
        input  sel, digits, digits_valid, busy
    );

    modport slave (
        input  src0, src1, src2, src3, lock,
        output sel, digits, digits_valid, busy
    );

endinterface

// File: rtl/ssd_display_controller_btn_debounce.sv
// Push-button conditioner: two-flop synchronizer followed by a stability
// counter; emits the accepted level and a one-cycle pulse on its rising edge.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);

    localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;
    logic             w_sync;

    assign w_sync = r_sync[1];

    // NOTE: every register here is updated with <= so all of them sample the
    // pre-edge values; blocking assignments would make the result order-dependent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= 2'b00;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_btn};
            r_rise <= 1'b0;
            if (w_sync == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_level <= w_sync;
                r_rise  <= w_sync;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;

endmodule

// File: rtl/ssd_display_controller.sv
// Selects one of four debug values, resamples it periodically and converts it
// to packed BCD with a bit-serial double-dabble FSM for the display driver.
module ssd_display_controller
    import ssd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SAMPLE_CYCLES   = 2_500_000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     btn_next,
    ssd_display_controller_if.slave  bus
);

    localparam int               TMR_W     = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(SAMPLE_CYCLES - 1);
    localparam logic [3:0]       ITER_LAST = 4'(NUM_W - 1);

    logic             w_btn_level;
    logic             w_btn_rise;
    logic             w_press;
    logic             w_tick;
    logic             w_req;
    logic             w_leave;
    logic [NUM_W-1:0] w_src_sel;

    logic [TMR_W-1:0] r_timer;
    logic [1:0]       r_sel;
    logic             r_pending;
    state_t           r_state;
    logic [NUM_W-1:0] r_bin;
    logic [BCD_W-1:0] r_bcd;
    logic [3:0]       r_iter;
    logic [BCD_W-1:0] r_digits;
    logic             r_valid;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_next),
        .o_level (w_btn_level),
        .o_rise  (w_btn_rise)
    );

    assign w_press = w_btn_rise & w_btn_level;
    assign w_tick  = (r_timer == TMR_LAST);
    assign w_req   = ~bus.lock & (w_press | w_tick);
    assign w_leave = (r_state == IDLE) & r_pending;

    // NOTE: the default assignment ahead of the case keeps this purely
    // combinational; a path that leaves w_src_sel unassigned would infer a latch.
    always_comb begin
        w_src_sel = bus.src0;
        case (r_sel)
            2'd1:    w_src_sel = bus.src1;
            2'd2:    w_src_sel = bus.src2;
            2'd3:    w_src_sel = bus.src3;
            default: w_src_sel = bus.src0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer   <= '0;
            r_sel     <= 2'd0;
            r_pending <= 1'b1;
        end else begin
            r_timer <= w_tick ? '0 : r_timer + TMR_W'(1);
            if (w_press && !bus.lock)
                r_sel <= r_sel + 2'd1;
            // A new request wins over the clear, so nothing arriving on the hand-off cycle is lost.
            r_pending <= w_req | (r_pending & ~w_leave);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_bin    <= '0;
            r_bcd    <= '0;
            r_iter   <= 4'd0;
            r_digits <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_pending) begin
                        r_bin   <= w_src_sel;
                        r_bcd   <= '0;
                        r_iter  <= 4'd0;
                        r_state <= CONV;
                    end
                end
                CONV: begin
                    {r_bcd, r_bin} <= {bcd_add3(r_bcd), r_bin} << 1;
                    if (r_iter == ITER_LAST)
                        r_state <= DONE;
                    else
                        r_iter <= r_iter + 4'd1;
                end
                DONE: begin
                    r_digits <= r_bcd;
                    r_valid  <= 1'b1;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.sel          = r_sel;
    assign bus.digits       = r_digits;
    assign bus.digits_valid = r_valid;
    assign bus.busy         = (r_state != IDLE);

endmodule
